// File: rtl/dram_arbiter.sv
// dram_arbiter: N-channel round-robin request arbiter in front of the DRAM
// buffer/controller. Requests pass through a single registered output stage.
// Read requests record the issuing channel in an order FIFO so that in-order
// controller responses are steered back to the right master.
module dram_arbiter #(
  parameter int N_CH    = 2,
  parameter int ADDR_W  = 27,
  parameter int DATA_W  = 128,
  parameter int MAX_OUT = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_CH-1:0]            req_valid,
  output logic [N_CH-1:0]            req_ready,
  input  logic [N_CH-1:0]            req_we,
  input  logic [N_CH*ADDR_W-1:0]     req_addr,
  input  logic [N_CH*DATA_W-1:0]     req_wdata,
  output logic [N_CH-1:0]            rsp_valid,
  output logic [DATA_W-1:0]          rsp_rdata,
  output logic                       m_req_valid,
  input  logic                       m_req_ready,
  output logic                       m_req_we,
  output logic [ADDR_W-1:0]          m_req_addr,
  output logic [DATA_W-1:0]          m_req_wdata,
  input  logic                       m_rsp_valid,
  input  logic [DATA_W-1:0]          m_rsp_rdata,
  output logic [$clog2(MAX_OUT):0]   rd_outstanding,
  output logic                       err
);

  localparam int CH_W = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int AW   = $clog2(MAX_OUT);
  localparam int CW   = AW + 1;

  localparam logic [0:0] OREG_EMPTY = 1'b0;
  localparam logic [0:0] OREG_FULL  = 1'b1;

  logic [0:0]      ostate;
  logic [CH_W-1:0] rr_ptr;
  logic [CH_W-1:0] rr_next;
  logic [N_CH-1:0] eligible;
  logic            grant_any;
  logic [CH_W-1:0] grant_idx;
  int unsigned     scan_idx;
  int unsigned     rr_tmp;
  logic            slot_free;
  logic            accept;
  logic            push;
  logic            pop;
  logic [N_CH-1:0] rsp_hit;

  logic [CH_W-1:0] tag_mem [MAX_OUT];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count;

  // A read only competes while the order FIFO has room; writes always may.
  // The free-slot test uses the registered count, so a same-cycle pop does
  // not open a slot.
  assign eligible    = req_valid & (req_we | {N_CH{count < CW'(MAX_OUT)}});
  assign slot_free   = (ostate == OREG_EMPTY) | m_req_ready;
  assign accept      = slot_free & grant_any & ~rst;
  assign push        = accept & ~req_we[grant_idx];
  assign pop         = m_rsp_valid & (count != '0);
  assign m_req_valid = (ostate == OREG_FULL);
  assign rd_outstanding = count;

  // Round-robin scan: first eligible channel starting at rr_ptr.
  always_comb begin
    grant_any = 1'b0;
    grant_idx = '0;
    scan_idx  = 0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      scan_idx = (32'(rr_ptr) + k) % N_CH;
      if (!grant_any && eligible[scan_idx[CH_W-1:0]]) begin
        grant_any = 1'b1;
        grant_idx = scan_idx[CH_W-1:0];
      end
    end
    rr_tmp  = (32'(grant_idx) + 32'd1) % N_CH;
    rr_next = rr_tmp[CH_W-1:0];
  end

  // One-hot accept back to the winning master.
  always_comb begin
    req_ready = '0;
    if (accept) req_ready[grant_idx] = 1'b1;
  end

  // Output register: load on accept (which may coincide with a drain),
  // otherwise empty when the downstream side takes the held request.
  always_ff @(posedge clk) begin
    if (rst) begin
      ostate      <= OREG_EMPTY;
      m_req_we    <= 1'b0;
      m_req_addr  <= '0;
      m_req_wdata <= '0;
      rr_ptr      <= '0;
    end else if (accept) begin
      ostate      <= OREG_FULL;
      m_req_we    <= req_we[grant_idx];
      m_req_addr  <= req_addr[grant_idx*ADDR_W +: ADDR_W];
      m_req_wdata <= req_wdata[grant_idx*DATA_W +: DATA_W];
      rr_ptr      <= rr_next;
    end else if (m_req_ready) begin
      ostate      <= OREG_EMPTY;
    end
  end

  // Order FIFO storage: channel id of each issued read.
  always_ff @(posedge clk) begin
    if (push) tag_mem[wr_ptr] <= grant_idx;
  end

  // Order FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      count <= count + CW'(1);
      else if (pop && !push) count <= count - CW'(1);
    end
  end

  // Steer the popped response to its channel.
  always_comb begin
    rsp_hit = '0;
    if (pop) rsp_hit[tag_mem[rd_ptr]] = 1'b1;
  end

  // Registered response strobe/data and sticky error on unmatched responses.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= '0;
      rsp_rdata <= '0;
      err       <= 1'b0;
    end else begin
      rsp_valid <= rsp_hit;
      if (pop) rsp_rdata <= m_rsp_rdata;
      if (m_rsp_valid && count == '0) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Self-checking bench for dram_arbiter: directed scenarios plus randomized
// traffic against a queue-based reference model.
module tb_dram_arbiter;
  localparam int N_CH = 2, ADDR_W = 27, DATA_W = 128, MAX_OUT = 4;

  logic clk = 1'b0;
  logic rst;
  logic [N_CH-1:0] req_valid, req_ready, req_we, rsp_valid;
  logic [N_CH*ADDR_W-1:0] req_addr;
  logic [N_CH*DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rsp_rdata, m_req_wdata, m_rsp_rdata;
  logic m_req_valid, m_req_ready, m_req_we, m_rsp_valid, err;
  logic [ADDR_W-1:0] m_req_addr;
  logic [2:0] rd_outstanding;

  dram_arbiter #(.N_CH(N_CH), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_we(m_req_we),
    .m_req_addr(m_req_addr), .m_req_wdata(m_req_wdata), .m_rsp_valid(m_rsp_valid),
    .m_rsp_rdata(m_rsp_rdata), .rd_outstanding(rd_outstanding), .err(err));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model state
  bit                mdl_held;
  logic              mdl_we;
  logic [ADDR_W-1:0] mdl_addr;
  logic [DATA_W-1:0] mdl_wdata;
  int                tagq[$];
  int                mdl_rr;
  logic              mdl_err;
  logic [N_CH-1:0]   mdl_rsp_valid;
  logic [DATA_W-1:0] mdl_rsp_rdata;

  function automatic int model_winner();
    int c;
    if (rst) return -1;
    if (mdl_held && !m_req_ready) return -1;
    for (int k = 0; k < N_CH; k++) begin
      c = (mdl_rr + k) % N_CH;
      if (req_valid[c] && (req_we[c] || tagq.size() < MAX_OUT)) return c;
    end
    return -1;
  endfunction

  function automatic logic [N_CH-1:0] exp_ready();
    int w;
    w = model_winner();
    if (w < 0) return '0;
    return N_CH'(1) << w;
  endfunction

  task automatic model_reset();
    mdl_held = 0; mdl_we = 0; mdl_addr = '0; mdl_wdata = '0;
    tagq.delete(); mdl_rr = 0; mdl_err = 0; mdl_rsp_valid = '0; mdl_rsp_rdata = '0;
  endtask

  // Advance one clock and update the model with the inputs seen at the edge.
  task automatic tick();
    int w, h;
    w = model_winner();
    @(posedge clk);
    if (rst) model_reset();
    else begin
      mdl_rsp_valid = '0;
      if (m_rsp_valid) begin
        if (tagq.size() > 0) begin
          h = tagq.pop_front();
          mdl_rsp_valid = N_CH'(1) << h;
          mdl_rsp_rdata = m_rsp_rdata;
        end else mdl_err = 1'b1;
      end
      if (mdl_held && m_req_ready) mdl_held = 0;
      if (w >= 0) begin
        mdl_held  = 1;
        mdl_we    = req_we[w];
        mdl_addr  = req_addr[w*ADDR_W +: ADDR_W];
        mdl_wdata = req_wdata[w*DATA_W +: DATA_W];
        mdl_rr    = (w + 1) % N_CH;
        if (!req_we[w]) tagq.push_back(w);
      end
    end
    #1;
  endtask

  task automatic idle();
    req_valid = '0; req_we = '0; m_req_ready = 1'b0; m_rsp_valid = 1'b0;
  endtask

  task automatic set_req(input int c, input logic we, input logic [ADDR_W-1:0] a,
                         input logic [DATA_W-1:0] d);
    req_we[c] = we;
    req_addr[c*ADDR_W +: ADDR_W] = a;
    req_wdata[c*DATA_W +: DATA_W] = d;
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; idle(); req_valid = '1;
    #1;
    checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_ready: got %b expected 00", req_ready); end
    do_reset();
    checks++; if (m_req_valid !== 1'b0) begin errors++; $display("FAIL reset_m_req_valid: got %b expected 0", m_req_valid); end
    checks++; if (rsp_valid !== '0) begin errors++; $display("FAIL reset_rsp_valid: got %b expected 00", rsp_valid); end
    checks++; if (rd_outstanding !== 3'd0) begin errors++; $display("FAIL reset_outstanding: got %0d expected 0", rd_outstanding); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected 0", err); end
    checks++; if (rsp_rdata !== '0) begin errors++; $display("FAIL reset_rsp_rdata: got %h expected 0", rsp_rdata); end
  endtask

  task automatic test_single_read();
    do_reset();
    set_req(0, 1'b0, 27'h100, '0);
    req_valid = 2'b01;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL single_ready: got %b expected 01", req_ready); end
    tick();
    req_valid = '0;
    checks++; if (m_req_valid !== 1'b1 || m_req_addr !== 27'h100 || m_req_we !== 1'b0) begin
      errors++; $display("FAIL single_issue: got v=%b a=%h we=%b expected v=1 a=100 we=0", m_req_valid, m_req_addr, m_req_we); end
    checks++; if (rd_outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding: got %0d expected 1", rd_outstanding); end
    m_req_ready = 1'b1;
    tick();
    checks++; if (m_req_valid !== 1'b0) begin errors++; $display("FAIL single_drain: got %b expected 0", m_req_valid); end
    m_rsp_valid = 1'b1; m_rsp_rdata = 128'hDEAD;
    tick();
    m_rsp_valid = 1'b0;
    checks++; if (rsp_valid !== 2'b01 || rsp_rdata !== 128'hDEAD) begin
      errors++; $display("FAIL single_rsp: got v=%b d=%h expected v=01 d=dead", rsp_valid, rsp_rdata); end
    checks++; if (rd_outstanding !== 3'd0) begin errors++; $display("FAIL single_outstanding_end: got %0d expected 0", rd_outstanding); end
    tick();
    checks++; if (rsp_valid !== 2'b00 || rsp_rdata !== 128'hDEAD) begin
      errors++; $display("FAIL single_rsp_hold: got v=%b d=%h expected v=00 d=dead", rsp_valid, rsp_rdata); end
  endtask

  task automatic test_round_robin();
    logic [N_CH-1:0] want;
    logic [ADDR_W-1:0] want_addr;
    do_reset();
    set_req(0, 1'b1, 27'h10, 128'h1111);
    set_req(1, 1'b1, 27'h20, 128'h2222);
    req_valid = 2'b11; m_req_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      want = N_CH'(1) << (i % N_CH);
      want_addr = (i % N_CH == 0) ? 27'h10 : 27'h20;
      #1;
      checks++; if (req_ready !== want) begin errors++; $display("FAIL rr_grant[%0d]: got %b expected %b", i, req_ready, want); end
      tick();
      checks++; if (m_req_valid !== 1'b1 || m_req_addr !== want_addr) begin
        errors++; $display("FAIL rr_out[%0d]: got v=%b a=%h expected v=1 a=%h", i, m_req_valid, m_req_addr, want_addr); end
    end
    idle();
  endtask

  task automatic test_fifo_full();
    do_reset();
    set_req(1, 1'b0, 27'h300, '0);
    set_req(0, 1'b1, 27'h40, 128'hABCD);
    req_valid = 2'b10; m_req_ready = 1'b1;
    for (int i = 0; i < MAX_OUT; i++) begin
      #1;
      checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL full_fill[%0d]: got %b expected 10", i, req_ready); end
      tick();
    end
    checks++; if (rd_outstanding !== 3'd4) begin errors++; $display("FAIL full_count: got %0d expected 4", rd_outstanding); end
    req_valid = 2'b11;
    #1;
    checks++; if (req_ready !== 2'b01) begin errors++; $display("FAIL full_write_pass: got %b expected 01", req_ready); end
    tick();
    req_valid = 2'b10;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_stall: got %b expected 00", req_ready); end
    tick();
    m_rsp_valid = 1'b1; m_rsp_rdata = 128'h55;
    #1;
    checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL full_no_bypass: got %b expected 00", req_ready); end
    tick();
    m_rsp_valid = 1'b0;
    checks++; if (rd_outstanding !== 3'd3 || rsp_valid !== 2'b10) begin
      errors++; $display("FAIL full_pop: got cnt=%0d v=%b expected cnt=3 v=10", rd_outstanding, rsp_valid); end
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL full_resume: got %b expected 10", req_ready); end
    tick();
    checks++; if (rd_outstanding !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d expected 4", rd_outstanding); end
    idle();
  endtask

  task automatic test_ordering();
    int seq[3] = '{0, 1, 0};
    logic [DATA_W-1:0] d;
    do_reset();
    m_req_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      req_valid = N_CH'(1) << seq[i];
      set_req(seq[i], 1'b0, ADDR_W'(32'h500 + i), '0);
      #1;
      checks++; if (req_ready !== (N_CH'(1) << seq[i])) begin errors++; $display("FAIL order_issue[%0d]: got %b", i, req_ready); end
      tick();
    end
    req_valid = '0;
    tick();
    checks++; if (rd_outstanding !== 3'd3) begin errors++; $display("FAIL order_count: got %0d expected 3", rd_outstanding); end
    for (int i = 0; i < 3; i++) begin
      d = {$urandom, $urandom, $urandom, $urandom};
      m_rsp_valid = 1'b1; m_rsp_rdata = d;
      tick();
      checks++; if (rsp_valid !== (N_CH'(1) << seq[i]) || rsp_rdata !== d) begin
        errors++; $display("FAIL order_rsp[%0d]: got v=%b d=%h expected v=%b d=%h", i, rsp_valid, rsp_rdata, N_CH'(1) << seq[i], d); end
    end
    m_rsp_valid = 1'b0;
    checks++; if (rd_outstanding !== 3'd0 || err !== 1'b0) begin
      errors++; $display("FAIL order_end: got cnt=%0d err=%b expected 0 0", rd_outstanding, err); end
    idle();
  endtask

  task automatic test_backpressure();
    do_reset();
    set_req(0, 1'b1, 27'h7A0, 128'hCAFE);
    req_valid = 2'b01;
    tick();
    set_req(0, 1'b1, 27'h7B0, 128'hBEEF);
    set_req(1, 1'b1, 27'h7C0, 128'hF00D);
    req_valid = 2'b11;
    for (int i = 0; i < 5; i++) begin
      #1;
      checks++; if (req_ready !== 2'b00) begin errors++; $display("FAIL bp_ready[%0d]: got %b expected 00", i, req_ready); end
      tick();
      checks++; if (m_req_valid !== 1'b1 || m_req_addr !== 27'h7A0 || m_req_wdata !== 128'hCAFE) begin
        errors++; $display("FAIL bp_hold[%0d]: got v=%b a=%h d=%h expected v=1 a=7a0 d=cafe", i, m_req_valid, m_req_addr, m_req_wdata); end
    end
    m_req_ready = 1'b1;
    #1;
    checks++; if (req_ready !== 2'b10) begin errors++; $display("FAIL bp_release: got %b expected 10", req_ready); end
    tick();
    checks++; if (m_req_valid !== 1'b1 || m_req_addr !== 27'h7C0 || m_req_wdata !== 128'hF00D) begin
      errors++; $display("FAIL bp_next: got v=%b a=%h d=%h expected v=1 a=7c0 d=f00d", m_req_valid, m_req_addr, m_req_wdata); end
    idle();
  endtask

  task automatic test_error_reset();
    do_reset();
    m_rsp_valid = 1'b1; m_rsp_rdata = 128'h99;
    tick();
    m_rsp_valid = 1'b0;
    checks++; if (err !== 1'b1 || rsp_valid !== 2'b00) begin
      errors++; $display("FAIL err_set: got err=%b v=%b expected 1 00", err, rsp_valid); end
    tick();
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b expected 1", err); end
    m_req_ready = 1'b1;
    set_req(0, 1'b0, 27'h11, '0); set_req(1, 1'b0, 27'h22, '0);
    req_valid = 2'b01; tick();
    req_valid = 2'b10; tick();
    req_valid = '0;
    checks++; if (rd_outstanding !== 3'd2 || m_req_valid !== 1'b1) begin
      errors++; $display("FAIL err_pre_rst: got cnt=%0d v=%b expected 2 1", rd_outstanding, m_req_valid); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (rd_outstanding !== 3'd0 || m_req_valid !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL err_rst: got cnt=%0d v=%b err=%b expected 0 0 0", rd_outstanding, m_req_valid, err); end
    m_rsp_valid = 1'b1;
    tick();
    m_rsp_valid = 1'b0;
    checks++; if (err !== 1'b1 || rsp_valid !== 2'b00) begin
      errors++; $display("FAIL err_late: got err=%b v=%b expected 1 00", err, rsp_valid); end
    idle();
  endtask

  task automatic test_random();
    logic [N_CH-1:0] want;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      rst = ($urandom_range(0, 99) == 0);
      req_valid = N_CH'($urandom);
      req_we = N_CH'($urandom);
      for (int c = 0; c < N_CH; c++) begin
        req_addr[c*ADDR_W +: ADDR_W] = ADDR_W'($urandom);
        req_wdata[c*DATA_W +: DATA_W] = {$urandom, $urandom, $urandom, $urandom};
      end
      m_req_ready = ($urandom_range(0, 9) < 7);
      m_rsp_valid = (tagq.size() > 0 && $urandom_range(0, 2) == 0) || ($urandom_range(0, 63) == 0);
      m_rsp_rdata = {$urandom, $urandom, $urandom, $urandom};
      #1;
      want = exp_ready();
      checks++; if (req_ready !== want) begin errors++; $display("FAIL rand_ready[%0d]: got %b expected %b", i, req_ready, want); end
      tick();
      checks++; if (m_req_valid !== mdl_held || (mdl_held && (m_req_we !== mdl_we || m_req_addr !== mdl_addr || m_req_wdata !== mdl_wdata))) begin
        errors++; $display("FAIL rand_out[%0d]: got v=%b we=%b a=%h expected v=%b we=%b a=%h", i, m_req_valid, m_req_we, m_req_addr, mdl_held, mdl_we, mdl_addr); end
      checks++; if (rsp_valid !== mdl_rsp_valid || rsp_rdata !== mdl_rsp_rdata) begin
        errors++; $display("FAIL rand_rsp[%0d]: got v=%b d=%h expected v=%b d=%h", i, rsp_valid, rsp_rdata, mdl_rsp_valid, mdl_rsp_rdata); end
      checks++; if (rd_outstanding !== 3'(tagq.size()) || err !== mdl_err) begin
        errors++; $display("FAIL rand_state[%0d]: got cnt=%0d err=%b expected cnt=%0d err=%b", i, rd_outstanding, err, tagq.size(), mdl_err); end
    end
    rst = 1'b0;
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    req_addr = '0; req_wdata = '0; m_rsp_rdata = '0;
    idle();
    model_reset();
    test_reset();
    test_single_read();
    test_round_robin();
    test_fifo_full();
    test_ordering();
    test_backpressure();
    test_error_reset();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/dram_arbiter.md
Name: dram_arbiter

Overview:
- N-channel round-robin arbiter that merges several master request streams (cache, instruction fetch, test master) onto the single request/response channel feeding the DRAM buffer and controller.
- Write requests carry data. Read requests are tagged internally so in-order read responses from the controller are routed back to the issuing channel.
- Generalises the single-master DRAM path to N_CH masters, with:
  - bounded outstanding-read tracking,
  - a registered output stage,
  - error flagging.

Parameters:
N_CH, 2, number of upstream masters (2..8)
ADDR_W, 27, request address width
DATA_W, 128, request/response data width
MAX_OUT, 4, max outstanding reads tracked (power of 2, >=2)

Ports:
clk  in  1  single clock for all logic
rst  in  1  synchronous, active-high reset
req_valid  in  N_CH  per-channel request valid
req_ready  out  N_CH  per-channel accept (combinational)
req_we  in  N_CH  per-channel 1=write, 0=read
req_addr  in  N_CH*ADDR_W  channel i at [i*ADDR_W +: ADDR_W]
req_wdata  in  N_CH*DATA_W  channel i at [i*DATA_W +: DATA_W]
rsp_valid  out  N_CH  one-cycle read-data strobe per channel
rsp_rdata  out  DATA_W  read data, shared by all channels
m_req_valid  out  1  downstream request valid
m_req_ready  in  1  downstream accept
m_req_we  out  1  downstream write flag
m_req_addr  out  ADDR_W  downstream address
m_req_wdata  out  DATA_W  downstream write data
m_rsp_valid  in  1  downstream read data valid (in issue order)
m_rsp_rdata  in  DATA_W  downstream read data
rd_outstanding  out  $clog2(MAX_OUT)+1  current outstanding-read count
err  out  1  sticky: response received with no outstanding read

Behaviour:
- Reset values:
  - All outputs 0.
  - rr_ptr=0; order FIFO empty (rd_outstanding=0).
  - Output register empty.
  - Any held request is dropped.
- Output register states:
  - EMPTY: m_req_valid=0.
  - FULL: m_req_valid=1, holding {we, addr, wdata} stable until m_req_ready=1.
- Slot free: slot_free = EMPTY | (m_req_valid & m_req_ready).
- Eligibility: channel i is eligible when req_valid[i] & (req_we[i] | rd_outstanding < MAX_OUT).
  - A pop in the same cycle does not free a read slot; no bypass.
- Arbitration, when slot_free:
  - Winner = first eligible channel scanning rr_ptr, rr_ptr+1, ... modulo N_CH.
  - req_ready[winner]=1 combinationally; all other req_ready bits are 0.
  - If slot_free=0, all req_ready bits are 0.
- Accept:
  - Next cycle the output register holds the winner's request and m_req_valid=1. Latency from accept to m_req_valid is 1 cycle.
  - rr_ptr <= (winner+1) mod N_CH.
  - If no channel is eligible, rr_ptr is unchanged.
- Back-to-back: a drain (m_req_ready) and a new accept in the same cycle give continuous m_req_valid=1 with one request per cycle.
- Read issue: on a read accept, the winner index is pushed into the order FIFO and rd_outstanding increments.
- Read response:
  - On m_rsp_valid with the FIFO non-empty: pop the head id h.
  - Next cycle: rsp_valid[h]=1 for exactly one cycle, rsp_rdata = m_rsp_rdata captured.
  - rd_outstanding decrements.
- Simultaneous push and pop: count unchanged; FIFO pointers wrap modulo MAX_OUT.
- Unexpected response: m_rsp_valid with the FIFO empty is discarded, err <= 1 (sticky until rst), and rsp_valid stays 0.
- Writes produce no response and do not occupy the order FIFO.
- Reset mid-operation:
  - A pending output request is dropped.
  - Outstanding read tags are flushed.
  - Late responses after reset set err.
- rsp_rdata holds its last value when rsp_valid=0.

Test Plan:
- Single read: ch0 read addr 0x100 -> req_ready[0]=1 in the same cycle; m_req_valid=1 next cycle with addr 0x100, we=0; controller returns 0xDEAD -> rsp_valid[0]=1 for one cycle 1 cycle later, rsp_rdata=0xDEAD, rd_outstanding returns to 0.
- Round robin: N_CH=2, both channels hold valid writes continuously, m_req_ready=1 -> grants alternate 0,1,0,1; m_req_valid stays high every cycle.
- Order FIFO full: ch1 issues 4 reads with no responses -> rd_outstanding=4; a 5th read is stalled (req_ready[1]=0) while a ch0 write is still granted; one response returns -> the 5th read is accepted the cycle after the pop.
- Out-of-channel ordering: reads issued ch0, ch1, ch0 -> 3 responses map to rsp_valid[0], rsp_valid[1], rsp_valid[0] in that order.
- Backpressure: m_req_ready=0 for 5 cycles while a request is held -> m_req_valid/addr/wdata stable, all req_ready=0; m_req_ready=1 -> drain, plus a new accept in the same cycle.
- Error and reset: m_rsp_valid pulse with rd_outstanding=0 -> err=1 and no rsp_valid; assert rst with 2 reads outstanding -> next cycle rd_outstanding=0, m_req_valid=0, err=0.
